// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE,
      OWNER_LD,
      OWNER_DATA,
      OWNER_FETCH
   } arb_owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RESP
   } arb_state_e;

   localparam int ARB_MAX_LATENCY = 7;

   // Bit positions of each requester in the request/grant vectors.
   localparam int REQ_LD    = 0;
   localparam int REQ_DATA  = 1;
   localparam int REQ_FETCH = 2;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner select: loader > data > fetch, except that a raised
// starve flag lets fetch beat data. Returns a one-hot grant (or zero).
module arb_prio_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic       starve,
   output logic [2:0] gnt
);

   always_comb begin
      gnt = 3'b000;
      if (req[REQ_LD]) begin
         gnt[REQ_LD] = 1'b1;
      end else if (req[REQ_FETCH] && starve) begin
         gnt[REQ_FETCH] = 1'b1;
      end else if (req[REQ_DATA]) begin
         gnt[REQ_DATA] = 1'b1;
      end else if (req[REQ_FETCH]) begin
         gnt[REQ_FETCH] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates loader / data / fetch onto one fixed-latency memory port.
// Define ARB_PERF_CNT_EN to add the wait and starvation-hit counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_wdata,
   output logic              ld_ready,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              if_stall,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_if_wait,
   output logic [31:0]       perf_d_wait,
   output logic [15:0]       perf_starve_hits
`endif
);

   localparam logic [2:0] LAT        = 3'(MEM_LATENCY);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   arb_state_e  state_q, state_d;
   logic [2:0]  lat_q, lat_d;
   logic [7:0]  starve_q;
   arb_owner_e  owner_q;
   logic [31:0] if_rdata_q, d_rdata_q;

   logic        starve;
   logic [2:0]  req_vec, gnt_vec, gnt_raw;
   logic        any_gnt, resp;

   assign req_vec = {if_req, d_req, ld_valid};
   assign starve  = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);

   arb_prio_sel u_prio_sel (
      .req    (req_vec),
      .starve (starve),
      .gnt    (gnt_vec)
   );

   // Arbitration only happens in IDLE and in the response cycle.
   assign gnt_raw = (state_q != ARB_BUSY) ? gnt_vec : 3'b000;
   assign any_gnt = |gnt_raw;
   assign resp    = (state_q == ARB_RESP);

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
         ARB_IDLE, ARB_RESP: begin
            if (any_gnt) begin
               lat_d   = LAT;
               state_d = (LAT == 3'd1) ? ARB_RESP : ARB_BUSY;
            end else if (state_q == ARB_RESP) begin
               lat_d   = 3'd0;
               state_d = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            lat_d = lat_q - 3'd1;
            if (lat_q == 3'd2) begin
               state_d = ARB_RESP;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            lat_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         lat_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q    <= OWNER_NONE;
         starve_q   <= 8'd0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         if (gnt_raw[REQ_LD]) begin
            owner_q <= OWNER_LD;
         end else if (gnt_raw[REQ_DATA]) begin
            owner_q <= OWNER_DATA;
         end else if (gnt_raw[REQ_FETCH]) begin
            owner_q <= OWNER_FETCH;
         end else if (resp) begin
            owner_q <= OWNER_NONE;
         end

         if (gnt_raw[REQ_FETCH]) begin
            starve_q <= 8'd0;
         end else if (gnt_raw[REQ_DATA] && if_req && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + 8'd1;
         end

         if (resp && owner_q == OWNER_FETCH) begin
            if_rdata_q <= mem_rdata;
         end
         if (resp && owner_q == OWNER_DATA) begin
            d_rdata_q <= mem_rdata;
         end
      end
   end

   // Outputs are forced low while reset is held, even with requests pending.
   assign ld_ready  = reset_n & gnt_raw[REQ_LD];
   assign d_gnt     = reset_n & gnt_raw[REQ_DATA];
   assign if_gnt    = reset_n & gnt_raw[REQ_FETCH];
   assign mem_req   = ld_ready | d_gnt | if_gnt;
   assign if_rvalid = resp && (owner_q == OWNER_FETCH);
   assign d_rvalid  = resp && (owner_q == OWNER_DATA);
   assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
   assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
   assign if_stall  = reset_n & ((if_req & ~if_gnt) | ((owner_q == OWNER_FETCH) & ~if_rvalid));
   assign d_stall   = reset_n & ((d_req & ~d_gnt) | ((owner_q == OWNER_DATA) & ~d_rvalid));

   always_comb begin
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'd0;
      if (ld_ready) begin
         mem_we    = 1'b1;
         mem_be    = 4'b0001 << ld_addr[1:0];
         mem_addr  = {ld_addr[ADDR_W-1:2], 2'b00};
         mem_wdata = {4{ld_wdata}};
      end else if (d_gnt) begin
         mem_we    = d_we;
         mem_be    = d_be;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_be    = 4'b1111;
         mem_addr  = if_addr;
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_if_wait     <= 32'd0;
         perf_d_wait      <= 32'd0;
         perf_starve_hits <= 16'd0;
      end else begin
         if (if_req && !gnt_raw[REQ_FETCH] && perf_if_wait != 32'hFFFF_FFFF) begin
            perf_if_wait <= perf_if_wait + 32'd1;
         end
         if (d_req && !gnt_raw[REQ_DATA] && perf_d_wait != 32'hFFFF_FFFF) begin
            perf_d_wait <= perf_d_wait + 32'd1;
         end
         // A hit is a fetch grant that data would otherwise have taken.
         if (gnt_raw[REQ_FETCH] && starve && d_req && perf_starve_hits != 16'hFFFF) begin
            perf_starve_hits <= perf_starve_hits + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// that tracks busy time, ownership and a word-addressed memory.
module tb_mem_port_arbiter;

   localparam int ML = 3;
   localparam int SL = 2;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ld_valid = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [7:0]    ld_wdata = '0;
   logic          ld_ready;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [31:0]   if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [3:0]    d_be = '0;
   logic [AW-1:0] d_addr = '0;
   logic [31:0]   d_wdata = '0;
   logic          d_gnt, d_rvalid;
   logic [31:0]   d_rdata;
   logic          if_stall, d_stall;
   logic          mem_req, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_if_wait, perf_d_wait;
   logic [15:0]   perf_starve_hits;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(ML), .STARVE_LIMIT(SL), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_ready  (ld_ready),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .if_stall  (if_stall),
      .d_stall   (d_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_if_wait     (perf_if_wait),
      .perf_d_wait      (perf_d_wait),
      .perf_starve_hits (perf_starve_hits)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model: requester codes 0=none 1=loader 2=data 3=fetch.
   int          busy_left, owner_m, starve_m, last_win, resp_due;
   logic [31:0] resp_val_m, last_if_rd, last_d_rd;
   bit          resp_we_m;
   logic [31:0] if_wait_m, d_wait_m;
   logic [15:0] hits_m;
   bit [31:0]   mem_m [int unsigned];
   int          gnt_log[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_read(input int unsigned wa);
      if (mem_m.exists(wa)) return mem_m[wa];
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic model_reset();
      busy_left  = 0;
      owner_m    = 0;
      starve_m   = 0;
      last_win   = 0;
      resp_due   = -1;
      resp_we_m  = 1'b0;
      resp_val_m = '0;
      last_if_rd = '0;
      last_d_rd  = '0;
      if_wait_m  = '0;
      d_wait_m   = '0;
      hits_m     = '0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_ctl"}, {19'd0, ld_ready, if_gnt, if_rvalid, d_gnt, d_rvalid,
                               if_stall, d_stall, mem_req, mem_we, mem_be}, 32'd0);
      check_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
      check_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
      check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
`ifdef ARB_PERF_CNT_EN
      check_eq({tag, "_perf"}, perf_if_wait | perf_d_wait | {16'd0, perf_starve_hits}, 32'd0);
`endif
   endtask

   // One clock cycle: compare at negedge, advance the model, move to posedge+1.
   task automatic step();
      int          win;
      bit          can, rv_if, rv_d, starve_f;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wdata, nv;
      int unsigned wa;
      @(negedge clk);
      can      = (busy_left == 0);
      rv_if    = can && owner_m == 3;
      rv_d     = can && owner_m == 2;
      starve_f = (SL != 0) && (starve_m == SL);
      win = 0;
      if (can) begin
         if (ld_valid) win = 1;
         else if (d_req && if_req && starve_f) win = 3;
         else if (d_req) win = 2;
         else if (if_req) win = 3;
      end
      e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
      case (win)
         1: begin
            e_we = 1'b1; e_be = 4'b0001 << ld_addr[1:0];
            e_addr = {ld_addr[AW-1:2], 2'b00}; e_wdata = {4{ld_wdata}};
         end
         2: begin e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata; end
         3: e_addr = if_addr;
         default: ;
      endcase

      check_eq("grant", {28'd0, mem_req, ld_ready, d_gnt, if_gnt},
               {28'd0, win != 0, win == 1, win == 2, win == 3});
      check_eq("rvalid", {30'd0, if_rvalid, d_rvalid}, {30'd0, rv_if, rv_d});
      check_eq("stall", {30'd0, if_stall, d_stall},
               {30'd0, (if_req && win != 3) || (owner_m == 3 && !rv_if),
                       (d_req && win != 2) || (owner_m == 2 && !rv_d)});
      check_eq("if_rdata", if_rdata, rv_if ? resp_val_m : last_if_rd);
      if (!(rv_d && resp_we_m)) check_eq("d_rdata", d_rdata, rv_d ? resp_val_m : last_d_rd);
      if (win != 0) begin
         check_eq("mem_we", {31'd0, mem_we}, {31'd0, e_we});
         check_eq("mem_addr", mem_addr, e_addr);
         if (win != 3) check_eq("mem_be", {28'd0, mem_be}, {28'd0, e_be});
         if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
      end
`ifdef ARB_PERF_CNT_EN
      check_eq("perf_if_wait", perf_if_wait, if_wait_m);
      check_eq("perf_d_wait", perf_d_wait, d_wait_m);
      check_eq("perf_starve_hits", {16'd0, perf_starve_hits}, {16'd0, hits_m});
`endif
      if (ld_ready) gnt_log.push_back(1);
      else if (d_gnt) gnt_log.push_back(2);
      else if (if_gnt) gnt_log.push_back(3);

      if (rv_if) last_if_rd = resp_val_m;
      if (rv_d) last_d_rd = resp_val_m;
      if (if_req && win != 3 && if_wait_m != 32'hFFFF_FFFF) if_wait_m++;
      if (d_req && win != 2 && d_wait_m != 32'hFFFF_FFFF) d_wait_m++;
      if (win == 3 && starve_f && d_req && hits_m != 16'hFFFF) hits_m++;
      if (win != 0) begin
         wa = e_addr[AW-1:2];
         resp_val_m = mem_read(wa);
         resp_we_m  = e_we;
         if (e_we) begin
            nv = resp_val_m;
            for (int i = 0; i < 4; i++) if (e_be[i]) nv[8*i +: 8] = e_wdata[8*i +: 8];
            mem_m[wa] = nv;
         end
         resp_due  = cyc + ML;
         busy_left = ML - 1;
         owner_m   = win;
         if (win == 3) starve_m = 0;
         else if (win == 2 && if_req && starve_m < SL) starve_m++;
      end else if (busy_left > 0) begin
         busy_left--;
      end else begin
         owner_m = 0;
      end
      last_win = win;

      @(posedge clk);
      cyc++;
      #1;
      mem_rdata = (cyc == resp_due) ? resp_val_m : $urandom();
   endtask

   // Requesters hold until granted; each may withdraw with probability p_wd/16.
   task automatic gen_inputs(input int p_ld, input int p_d, input int p_f, input int p_wd);
      if (!ld_valid || last_win == 1) begin
         ld_valid = int'($urandom_range(0, 15)) < p_ld;
         ld_addr  = $urandom_range(0, 63);
         ld_wdata = 8'($urandom());
      end else if (int'($urandom_range(0, 15)) < p_wd) ld_valid = 1'b0;
      if (!d_req || last_win == 2) begin
         d_req   = int'($urandom_range(0, 15)) < p_d;
         d_we    = 1'($urandom());
         d_be    = 4'($urandom());
         d_addr  = $urandom_range(0, 15) << 2;
         d_wdata = $urandom();
      end else if (int'($urandom_range(0, 15)) < p_wd) d_req = 1'b0;
      if (!if_req || last_win == 3) begin
         if_req  = int'($urandom_range(0, 15)) < p_f;
         if_addr = $urandom_range(0, 15) << 2;
      end else if (int'($urandom_range(0, 15)) < p_wd) if_req = 1'b0;
   endtask

   task automatic clear_inputs();
      ld_valid = 1'b0;
      d_req    = 1'b0;
      if_req   = 1'b0;
   endtask

   task automatic check_log(input string tag, input int exp[6], input int n);
      check_eq({tag, "_len_ok"}, {31'd0, gnt_log.size() >= n}, 32'd1);
      for (int i = 0; i < n; i++)
         if (i < gnt_log.size()) check_eq($sformatf("%s_%0d", tag, i), gnt_log[i], exp[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_order[6];
      model_reset();
      // Reset with every request raised: all outputs must stay low.
      reset_n = 1'b0;
      ld_valid = 1'b1; d_req = 1'b1; if_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      clear_inputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Loader byte write to address 7.
      ld_valid = 1'b1; ld_addr = 32'h0000_0007; ld_wdata = 8'hAB;
      #1;
      check_eq("ld_be", {28'd0, mem_be}, 32'h8);
      check_eq("ld_addr", mem_addr, 32'h4);
      check_eq("ld_wdata", mem_wdata, 32'hABAB_ABAB);
      step();
      ld_valid = 1'b0;
      repeat (ML + 1) step();

      // All three requesters raised together in IDLE.
      ld_valid = 1'b1; ld_addr = 32'h0000_000C; ld_wdata = 8'h5A;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0004; d_wdata = '0;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      gnt_log.delete();
      step();
      repeat (3 * ML + 2) begin gen_inputs(0, 0, 0, 0); step(); end
      exp_order = '{1, 2, 3, 0, 0, 0};
      check_log("order3", exp_order, 3);

      // Data and fetch both held high: fetch wins every (SL+1)th grant.
      gnt_log.delete();
      repeat (8 * ML) begin gen_inputs(0, 16, 16, 0); step(); end
      exp_order = '{2, 2, 3, 2, 2, 3};
      check_log("starve", exp_order, 6);

      repeat (1500) begin gen_inputs(3, 8, 10, 1); step(); end

      // Abort a data transaction with reset while it is in flight.
      for (int i = 0; i < 50; i++) begin
         gen_inputs(0, 12, 8, 1);
         step();
         if (last_win == 2) break;
      end
      check_eq("find_dgnt", last_win, 2);
      reset_n = 1'b0;
      d_req = 1'b1; if_req = 1'b1;
      #1;
      check_zero_outputs("midrst");
      @(posedge clk);
      #1;
      check_zero_outputs("midrst_hold");
      clear_inputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      resp_due = -1;
      repeat (ML + 2) step();
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0010;
      gnt_log.delete();
      step();
      check_eq("post_rst_gnt", gnt_log.size(), 1);
      d_req = 1'b0;

      repeat (1000) begin gen_inputs(0, 14, 14, 1); step(); end
      repeat (400) begin gen_inputs(2, 10, 6, 2); step(); end
      clear_inputs();
      repeat (ML + 2) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
